// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional bus-error timeout and DRAIN state enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_e;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout;
`else
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
`endif

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          drop_q, drop_d;
  logic          fetch_elig, win_d, win_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      drop_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
`ifdef ARB_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign fetch_elig = i_req & ~i_flush;
  assign win_d      = d_req & ((streak_q < SW'(MAX_D_STREAK)) | ~fetch_elig);
  assign win_i      = ~win_d & fetch_elig;

`ifdef ARB_TIMEOUT_EN
  assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_d = '0;
    if (state_q == BUSY_I || state_q == BUSY_D) timer_d = timer_q + TW'(1);
  end
`endif

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_err    = 1'b0;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_be     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    // Outputs are forced quiet while reset is held, even with requests pending.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (win_d) begin
            m_req   = 1'b1;
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            d_gnt   = m_gnt;
            if (m_gnt) state_d = BUSY_D;
          end else if (win_i) begin
            m_req   = 1'b1;
            m_be    = '1;
            m_addr  = i_addr;
            i_gnt   = m_gnt;
            if (m_gnt) begin
              state_d = BUSY_I;
              drop_d  = 1'b0;
            end
          end
        end
        BUSY_I: begin
          if (m_rvalid) begin
            i_rvalid = ~(drop_q | i_flush);
            i_rdata  = i_rvalid ? m_rdata : '0;
            i_err    = i_rvalid & m_err;
            state_d  = IDLE;
            drop_d   = 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout) begin
            i_rvalid = ~(drop_q | i_flush);
            i_err    = i_rvalid;
            state_d  = DRAIN;
            drop_d   = 1'b0;
          end
`endif
          else if (i_flush) begin
            drop_d = 1'b1;
          end
        end
        BUSY_D: begin
          if (m_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
            d_err    = m_err;
            state_d  = IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout) begin
            d_rvalid = 1'b1;
            d_err    = 1'b1;
            state_d  = DRAIN;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        DRAIN: begin
          if (m_rvalid) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) streak_d = '0;
    else if (d_gnt && (streak_q < SW'(MAX_D_STREAK))) streak_d = streak_q + SW'(1);
  end

  a_no_rvalid_on_grant: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IDLE && m_gnt && m_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [139:0] all_out;
  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err)
  );

  always #5 clk = ~clk;

  assign all_out = {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                    m_req, m_we, m_be, m_addr, m_wdata};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h20; d_wdata = 32'h5;
    m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
    step(); #1;
    n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", all_out); end
    step();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0; i_addr = '0;
    #1;
    n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL reset_idle: got %h want 0", all_out); end
  endtask

  task automatic test_lone_fetch();
    step(); i_req = 1'b1; i_addr = 32'h100; #1;
    n_vec++; if ({m_req, m_we, m_be, i_gnt, d_gnt} !== 8'b1_0_1111_1_0 || m_addr !== 32'h100 || m_wdata !== '0) begin
      n_err++; $display("FAIL fetch_grant: req/we/be/ig/dg=%b addr=%h want 10111110 addr=00000100", {m_req, m_we, m_be, i_gnt, d_gnt}, m_addr); end
    step(); i_req = 1'b0; #1;
    n_vec++; if ({m_req, i_gnt, i_rvalid, d_rvalid} !== 4'b0) begin
      n_err++; $display("FAIL fetch_busy: got %b want 0000", {m_req, i_gnt, i_rvalid, d_rvalid}); end
    step(); m_rvalid = 1'b1; m_rdata = 32'h0050_0093; #1;
    n_vec++; if ({i_rvalid, i_err, d_rvalid} !== 3'b100 || i_rdata !== 32'h0050_0093 || d_rdata !== '0) begin
      n_err++; $display("FAIL fetch_resp: v/e/dv=%b rdata=%h drdata=%h want 100 00500093 0", {i_rvalid, i_err, d_rvalid}, i_rdata, d_rdata); end
    step(); m_rvalid = 1'b0; m_rdata = '0; #1;
    n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL fetch_after: got %h want 0", all_out); end
  endtask

  task automatic test_contention();
    step(); i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'h1234_5678; #1;
    n_vec++; if ({m_req, m_we, m_be, i_gnt, d_gnt} !== 8'b1_1_0011_0_1 || m_addr !== 32'h2000 || m_wdata !== 32'h1234_5678) begin
      n_err++; $display("FAIL cont_d_first: got %b addr=%h wdata=%h want 11001101 2000 12345678", {m_req, m_we, m_be, i_gnt, d_gnt}, m_addr, m_wdata); end
    step(); d_req = 1'b0; #1;
    n_vec++; if ({m_req, i_gnt, d_gnt} !== 3'b000) begin n_err++; $display("FAIL cont_busy: got %b want 000", {m_req, i_gnt, d_gnt}); end
    step(); m_rvalid = 1'b1; #1;
    n_vec++; if ({d_rvalid, i_rvalid, i_gnt} !== 3'b100) begin n_err++; $display("FAIL cont_d_resp: got %b want 100", {d_rvalid, i_rvalid, i_gnt}); end
    step(); m_rvalid = 1'b0; #1;
    n_vec++; if ({m_req, m_we, m_be, i_gnt, d_gnt} !== 8'b1_0_1111_1_0 || m_addr !== 32'h104) begin
      n_err++; $display("FAIL cont_i_next: got %b addr=%h want 10111110 104", {m_req, m_we, m_be, i_gnt, d_gnt}, m_addr); end
    step(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; #1;
    n_vec++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFE_0001 || d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL cont_i_resp: v=%b rdata=%h dv=%b want 1 cafe0001 0", i_rvalid, i_rdata, d_rvalid); end
    step(); m_rvalid = 1'b0; m_rdata = '0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    i_req = 1'b1; i_addr = 32'h400; d_req = 1'b1; d_addr = 32'h3000; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 4 || k == 9) ? 2'b10 : 2'b01;
      #1;
      n_vec++; if ({i_gnt, d_gnt} !== exp) begin n_err++; $display("FAIL starve_gnt%0d: got %b want %b", k, {i_gnt, d_gnt}, exp); end
      step(); m_rvalid = 1'b1; m_rdata = k; #1;
      n_vec++; if ({i_rvalid, d_rvalid} !== exp) begin n_err++; $display("FAIL starve_resp%0d: got %b want %b", k, {i_rvalid, d_rvalid}, exp); end
      step(); m_rvalid = 1'b0;
    end
    i_req = 1'b0; d_req = 1'b0; d_addr = '0; d_be = '0; m_rdata = '0;
  endtask

  task automatic test_flush();
    step(); i_req = 1'b1; i_addr = 32'h200; #1;
    n_vec++; if (i_gnt !== 1'b1 || m_addr !== 32'h200) begin n_err++; $display("FAIL flush_grant: gnt=%b addr=%h want 1 200", i_gnt, m_addr); end
    step(); i_req = 1'b0; i_flush = 1'b1; #1;
    n_vec++; if ({m_req, i_rvalid} !== 2'b00) begin n_err++; $display("FAIL flush_busy: got %b want 00", {m_req, i_rvalid}); end
    step(); i_flush = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; #1;
    n_vec++; if ({i_rvalid, d_rvalid} !== 2'b00 || i_rdata !== '0) begin
      n_err++; $display("FAIL flush_drop: v/dv=%b rdata=%h want 00 0", {i_rvalid, d_rvalid}, i_rdata); end
    step(); m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h280; i_flush = 1'b1; #1;
    n_vec++; if ({m_req, i_gnt} !== 2'b00) begin n_err++; $display("FAIL flush_mask: got %b want 00", {m_req, i_gnt}); end
    step(); i_flush = 1'b0; i_addr = 32'h300; #1;
    n_vec++; if (i_gnt !== 1'b1 || m_addr !== 32'h300) begin n_err++; $display("FAIL flush_next_gnt: gnt=%b addr=%h want 1 300", i_gnt, m_addr); end
    step(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_2222; #1;
    n_vec++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL flush_next_resp: v=%b rdata=%h want 1 11112222", i_rvalid, i_rdata); end
    step(); m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic test_error_reset();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40; #1;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL err_gnt: got %b want 1", d_gnt); end
    step(); d_req = 1'b0; m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'hBAD; #1;
    n_vec++; if ({d_rvalid, d_err, i_rvalid, i_err} !== 4'b1100) begin n_err++; $display("FAIL err_resp: got %b want 1100", {d_rvalid, d_err, i_rvalid, i_err}); end
    step(); m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0; d_req = 1'b1; #1;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL rst_pre_gnt: got %b want 1", d_gnt); end
    step(); m_rvalid = 1'b1; m_rdata = 32'h77; #1;
    rst = 1'b1; #1;
    n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_mid: got %h want 0", all_out); end
    step(); rst = 1'b0; d_req = 1'b0; m_rvalid = 1'b0; m_rdata = '0; #1;
    n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_after: got %h want 0", all_out); end
    step(); d_req = 1'b1; #1;
    n_vec++; if (d_gnt !== 1'b1 || m_addr !== 32'h40) begin n_err++; $display("FAIL rst_idle_gnt: gnt=%b addr=%h want 1 40", d_gnt, m_addr); end
    step(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h99; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h99 || d_err !== 1'b0) begin
      n_err++; $display("FAIL rst_resp: v=%b rdata=%h err=%b want 1 99 0", d_rvalid, d_rdata, d_err); end
    step(); m_rvalid = 1'b0; m_rdata = '0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    d_req = 1'b1; d_addr = 32'h80; #1;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL to_gnt: got %b want 1", d_gnt); end
    early = 0;
    for (int c = 1; c < 8; c++) begin
      step(); d_req = 1'b0; #1;
      if (d_rvalid !== 1'b0) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early: got %0d early rvalids want 0", early); end
    step(); #1;
    n_vec++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== '0) begin
      n_err++; $display("FAIL to_fire: v/e=%b rdata=%h want 11 0", {d_rvalid, d_err}, d_rdata); end
    step(); d_req = 1'b1; #1;
    n_vec++; if ({m_req, d_gnt, d_rvalid} !== 3'b000) begin n_err++; $display("FAIL to_drain: got %b want 000", {m_req, d_gnt, d_rvalid}); end
    step(); step(); step(); m_rvalid = 1'b1; m_rdata = 32'h55; #1;
    n_vec++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL to_late: got %b want 0", d_rvalid); end
    step(); m_rvalid = 1'b0; m_rdata = '0; #1;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL to_idle: got %b want 1", d_gnt); end
    step(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h66; #1;
    n_vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h66) begin n_err++; $display("FAIL to_resume: v=%b rdata=%h want 1 66", d_rvalid, d_rdata); end
    step(); m_rvalid = 1'b0; m_rdata = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_error_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
